// File: rtl/alarm_pkg.sv
// alarm_pkg: shared STATE/FIELD encodings, key indices and default timing for the alarm clock.
package alarm_pkg;

    typedef enum logic [2:0] {
        ST_CLOCK     = 3'd0,
        ST_SET_TIME  = 3'd1,
        ST_SET_ALARM = 3'd2,
        ST_RINGING   = 3'd3,
        ST_SNOOZE    = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        FLD_NONE = 2'd0,
        FLD_HOUR = 2'd1,
        FLD_MIN  = 2'd2,
        FLD_SEC  = 2'd3
    } field_e;

    localparam int DEB_CYCLES_DEF   = 20000;
    localparam int RING_TIMEOUT_DEF = 60;
    localparam int SNOOZE_SEC_DEF   = 300;
    localparam int IDLE_TIMEOUT_DEF = 30;

    localparam int K_MODE  = 0;
    localparam int K_UP    = 1;
    localparam int K_DOWN  = 2;
    localparam int K_SHIFT = 3;
    localparam int K_OK    = 4;

    function automatic field_e next_field(input field_e f);
        return (f == FLD_SEC) ? FLD_HOUR : field_e'(f + 2'd1);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-FF synchronizer, stability counter and one-cycle pulse on the debounced rising edge.
module key_debounce #(
    parameter int DEB_CYCLES = 20000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_i,
    output logic rise_o
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          level_q;
    logic          rise_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q <= {sync_q[0], key_i};
            rise_q <= 1'b0;
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == LAST) begin
                // DEB_CYCLES-th consecutive differing sample: commit the new level
                level_q <= sync_q[1];
                rise_q  <= sync_q[1];
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/alarm_mode_ctrl.sv
// alarm_mode_ctrl: user-mode FSM for the alarm clock; conditions keys, gates edit strobes, runs the ring lifecycle.
module alarm_mode_ctrl
    import alarm_pkg::*;
#(
    parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
    parameter int RING_TIMEOUT = RING_TIMEOUT_DEF,
    parameter int SNOOZE_SEC   = SNOOZE_SEC_DEF,
    parameter int IDLE_TIMEOUT = IDLE_TIMEOUT_DEF
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       key_mode_i,
    input  logic       key_up_i,
    input  logic       key_down_i,
    input  logic       key_shift_i,
    input  logic       key_ok_i,
    input  logic       sec_tick_i,
    input  logic       alarm_hit_i,
    output logic [2:0] state_o,
    output logic [1:0] field_o,
    output logic       up_p_o,
    output logic       down_p_o,
    output logic       save_p_o,
    output logic       ring_o
);

    localparam int MAXV = (RING_TIMEOUT > SNOOZE_SEC)
        ? ((RING_TIMEOUT > IDLE_TIMEOUT) ? RING_TIMEOUT : IDLE_TIMEOUT)
        : ((SNOOZE_SEC > IDLE_TIMEOUT) ? SNOOZE_SEC : IDLE_TIMEOUT);
    localparam int CW = $clog2(MAXV + 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(MAXV);
    localparam logic [CW-1:0] RING_LAST = CW'(RING_TIMEOUT - 1);
    localparam logic [CW-1:0] SNZ_LAST  = CW'(SNOOZE_SEC - 1);
    localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_TIMEOUT - 1);

    logic [4:0] raw, evt;
    assign raw = {key_ok_i, key_shift_i, key_down_i, key_up_i, key_mode_i};

    genvar k;
    for (k = 0; k < 5; k++) begin : g_key
        key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .key_i  (raw[k]),
            .rise_o (evt[k])
        );
    end

    state_e        state_q, state_d;
    field_e        field_q, field_d;
    logic          up_q, up_d, dn_q, dn_d, save_q, save_d, hit_q, hit_rise;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

    always_comb begin
        cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        hit_rise = alarm_hit_i & ~hit_q;
        state_d  = state_q;
        field_d  = field_q;
        up_d     = 1'b0;
        dn_d     = 1'b0;
        save_d   = 1'b0;
        cnt_d    = sec_tick_i ? cnt_inc : cnt_q;
        case (state_q)
            ST_CLOCK: begin
                field_d = FLD_NONE;
                if (hit_rise) begin
                    state_d = ST_RINGING;
                end else if (evt[K_MODE]) begin
                    state_d = ST_SET_TIME;
                    field_d = FLD_HOUR;
                end
            end
            ST_SET_TIME, ST_SET_ALARM: begin
                if (|evt) cnt_d = '0;
                // SAVE_P is shown while still in the SET state, then the FSM leaves
                if (save_q) begin
                    state_d = ST_CLOCK;
                    field_d = FLD_NONE;
                end else if (evt[K_OK]) begin
                    save_d = 1'b1;
                end else if (evt[K_MODE]) begin
                    state_d = (state_q == ST_SET_TIME) ? ST_SET_ALARM : ST_CLOCK;
                    field_d = (state_q == ST_SET_TIME) ? FLD_HOUR : FLD_NONE;
                end else if (|evt) begin
                    field_d = evt[K_SHIFT] ? next_field(field_q) : field_q;
                    up_d    = evt[K_UP] & ~evt[K_DOWN];
                    dn_d    = evt[K_DOWN] & ~evt[K_UP];
                end else if (sec_tick_i && cnt_q == IDLE_LAST) begin
                    state_d = ST_CLOCK;
                    field_d = FLD_NONE;
                end
            end
            ST_RINGING: begin
                field_d = FLD_NONE;
                if (evt[K_OK]) state_d = ST_CLOCK;
                else if (evt[K_UP] | evt[K_DOWN] | evt[K_SHIFT]) state_d = ST_SNOOZE;
                else if (sec_tick_i && cnt_q == RING_LAST) state_d = ST_CLOCK;
            end
            ST_SNOOZE: begin
                field_d = FLD_NONE;
                if (evt[K_OK]) state_d = ST_CLOCK;
                else if (sec_tick_i && cnt_q == SNZ_LAST) state_d = ST_RINGING;
            end
            default: begin
                state_d = ST_CLOCK;
                field_d = FLD_NONE;
            end
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_CLOCK;
            field_q <= FLD_NONE;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
            save_q  <= 1'b0;
            hit_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            field_q <= field_d;
            up_q    <= up_d;
            dn_q    <= dn_d;
            save_q  <= save_d;
            hit_q   <= alarm_hit_i;
            cnt_q   <= cnt_d;
        end
    end

    assign state_o  = state_q;
    assign field_o  = field_q;
    assign up_p_o   = up_q;
    assign down_p_o = dn_q;
    assign save_p_o = save_q;
    assign ring_o   = (state_q == ST_RINGING);

endmodule

// File: tb/tb_alarm_mode_ctrl.sv
// tb_alarm_mode_ctrl: directed self-checking bench for alarm_mode_ctrl with short debounce and timeouts.
module tb_alarm_mode_ctrl;

    localparam logic [4:0] M_MODE  = 5'b00001;
    localparam logic [4:0] M_UP    = 5'b00010;
    localparam logic [4:0] M_DOWN  = 5'b00100;
    localparam logic [4:0] M_SHIFT = 5'b01000;
    localparam logic [4:0] M_OK    = 5'b10000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] keys = '0;
    logic       sec_tick = 1'b0;
    logic       alarm_hit = 1'b0;
    logic [2:0] state;
    logic [1:0] field;
    logic       up_p, down_p, save_p, ring;

    int n_cmp = 0, n_err = 0;
    int n_up = 0, n_dn = 0, n_save = 0, n_viol = 0;
    int up0, dn0;

    always #5 clk = ~clk;

    alarm_mode_ctrl #(
        .DEB_CYCLES   (4),
        .RING_TIMEOUT (3),
        .SNOOZE_SEC   (2),
        .IDLE_TIMEOUT (5)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .key_mode_i  (keys[0]),
        .key_up_i    (keys[1]),
        .key_down_i  (keys[2]),
        .key_shift_i (keys[3]),
        .key_ok_i    (keys[4]),
        .sec_tick_i  (sec_tick),
        .alarm_hit_i (alarm_hit),
        .state_o     (state),
        .field_o     (field),
        .up_p_o      (up_p),
        .down_p_o    (down_p),
        .save_p_o    (save_p),
        .ring_o      (ring)
    );

    always @(negedge clk) begin
        if (up_p === 1'b1) n_up++;
        if (down_p === 1'b1) n_dn++;
        if (save_p === 1'b1) n_save++;
        if ((up_p | down_p | save_p) === 1'b1 && !(state == 3'd1 || state == 3'd2)) n_viol++;
        if (int'(up_p) + int'(down_p) + int'(save_p) > 1) n_viol++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [4:0] m);
        keys = m;
        step(7);
    endtask

    task automatic release_keys();
        keys = '0;
        step(8);
    endtask

    task automatic tick();
        sec_tick = 1'b1;
        step(1);
        sec_tick = 1'b0;
    endtask

    initial begin
        step(3);
        chk("rst_state", 32'(state), 0);
        chk("rst_field", 32'(field), 0);
        chk("rst_strobes", 32'({up_p, down_p, save_p, ring}), 0);
        rst_n = 1'b1;
        step(2);

        // mode/shift walk and commit
        press(M_MODE);  chk("walk_st1", 32'(state), 1); chk("walk_f1", 32'(field), 1); release_keys();
        press(M_MODE);  chk("walk_st2", 32'(state), 2); chk("walk_f1b", 32'(field), 1); release_keys();
        press(M_SHIFT); chk("walk_f2", 32'(field), 2); release_keys();
        press(M_SHIFT); chk("walk_f3", 32'(field), 3); release_keys();
        press(M_SHIFT); chk("walk_f1c", 32'(field), 1); release_keys();
        press(M_SHIFT); chk("walk_f2b", 32'(field), 2); release_keys();
        press(M_OK);
        chk("ok_save", 32'(save_p), 1);
        chk("ok_state_hold", 32'(state), 2);
        step(1);
        chk("ok_save_off", 32'(save_p), 0);
        chk("ok_state_clk", 32'(state), 0);
        chk("ok_field", 32'(field), 0);
        release_keys();
        chk("ok_save_cnt", 32'(n_save), 1);

        // reset in the middle of SET_ALARM with an OK key pending
        press(M_MODE); release_keys();
        press(M_MODE); release_keys();
        press(M_SHIFT); release_keys();
        chk("pre_rst_st", 32'(state), 2);
        chk("pre_rst_f", 32'(field), 2);
        keys = M_OK;
        step(3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_st", 32'(state), 0);
        chk("async_rst_f", 32'(field), 0);
        step(3);
        chk("in_rst_strobes", 32'({up_p, down_p, save_p}), 0);
        keys = '0;
        rst_n = 1'b1;
        step(10);
        chk("post_rst_st", 32'(state), 0);
        chk("post_rst_save", 32'(n_save), 1);

        // bounce on UP in SET_TIME
        press(M_MODE); chk("bnc_st", 32'(state), 1); release_keys();
        up0 = n_up;
        repeat (3) begin
            keys = M_UP; step(2);
            keys = '0;   step(2);
        end
        keys = M_UP;
        for (int i = 1; i <= 10; i++) begin
            step(1);
            chk($sformatf("bnc_up_c%0d", i), 32'(up_p), (i == 7) ? 1 : 0);
        end
        release_keys();
        chk("bnc_up_once", 32'(n_up - up0), 1);
        press(M_DOWN); chk("down_p", 32'(down_p), 1); release_keys();
        press(M_MODE); chk("to_alarm", 32'(state), 2); release_keys();
        press(M_MODE); chk("alarm_discard", 32'(state), 0); release_keys();
        chk("discard_nosave", 32'(n_save), 1);

        // ringing, snooze, timeout
        alarm_hit = 1'b1;
        step(1);
        chk("ring_st", 32'(state), 3);
        chk("ring_on", 32'(ring), 1);
        up0 = n_up;
        press(M_UP);
        chk("snooze_st", 32'(state), 4);
        chk("snooze_ring", 32'(ring), 0);
        release_keys();
        tick(); chk("snooze_t1", 32'(state), 4);
        tick(); chk("resume_st", 32'(state), 3); chk("resume_ring", 32'(ring), 1);
        tick(); tick(); chk("ring_t2", 32'(state), 3);
        tick(); chk("timeout_st", 32'(state), 0); chk("timeout_ring", 32'(ring), 0);
        step(5);
        chk("no_retrigger", 32'(state), 0);
        chk("ring_no_up", 32'(n_up - up0), 0);
        alarm_hit = 1'b0;
        step(1);

        // alarm rise coinciding with the MODE event
        keys = M_MODE;
        step(6);
        alarm_hit = 1'b1;
        step(1);
        chk("alarm_wins", 32'(state), 3);
        release_keys();
        press(M_OK); chk("ok_stop", 32'(state), 0); chk("ok_stop_ring", 32'(ring), 0); release_keys();
        alarm_hit = 1'b0;
        step(1);

        // UP+DOWN together
        press(M_MODE); chk("ud_st", 32'(state), 1); release_keys();
        up0 = n_up; dn0 = n_dn;
        press(M_UP | M_DOWN);
        chk("ud_strobe", 32'({up_p, down_p}), 0);
        step(1);
        chk("ud_strobe2", 32'({up_p, down_p}), 0);
        release_keys();
        chk("ud_cnt", 32'((n_up - up0) + (n_dn - dn0)), 0);
        chk("ud_st_hold", 32'(state), 1);

        // idle timeout with restart
        repeat (4) tick();
        chk("idle_t4", 32'(state), 1);
        press(M_SHIFT); chk("idle_shift_f", 32'(field), 2); release_keys();
        repeat (4) tick();
        chk("idle_restart", 32'(state), 1);
        tick();
        chk("idle_out_st", 32'(state), 0);
        chk("idle_out_f", 32'(field), 0);
        chk("idle_nosave", 32'(n_save), 1);
        chk("strobe_rules", 32'(n_viol), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
